// File: rtl/mem_stage_pipe_if.sv
// Handshake bundle for the MEM stage: EX-side request fields and the registered WB result.
interface mem_stage_pipe_if #(
   parameter int DATA_W   = 32,
   parameter int ERRCNT_W = 8
);
   logic                in_valid;
   logic                in_ready;
   logic                read;
   logic                write;
   logic [1:0]          size;
   logic                sign_ext;
   logic [DATA_W-1:0]   aluResult;
   logic [DATA_W-1:0]   writedata;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   readdata;
   logic [DATA_W-1:0]   wbData;
   logic                mem_err;
   logic [ERRCNT_W-1:0] err_count;

   modport master (
      output in_valid, read, write, size, sign_ext, aluResult, writedata, out_ready,
      input  in_ready, out_valid, readdata, wbData, mem_err, err_count
   );

   modport slave (
      input  in_valid, read, write, size, sign_ext, aluResult, writedata, out_ready,
      output in_ready, out_valid, readdata, wbData, mem_err, err_count
   );
endinterface

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: byte-addressed data memory with sized loads/stores, a single registered
// result slot with valid/ready flow control, and a saturating count of misaligned accesses.
module mem_stage_pipe #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 8,
   parameter int ERRCNT_W   = 8
) (
   input logic             clk,
   input logic             rst,
   mem_stage_pipe_if.slave bus
);
   localparam int NB    = DATA_W / 8;
   localparam int WORDS = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem [WORDS];
   logic [DEPTH_LOG2-1:0] idx;
   logic [1:0]            lane;
   logic                  accept;
   logic                  is_store;
   logic                  is_load;
   logic                  bad_align;
   logic                  op_err;
   logic [DATA_W-1:0]     rd_word;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_W-1:0]     ld_data;
   logic [DATA_W-1:0]     st_data;
   logic [NB-1:0]         st_be;

   assign bus.in_ready = !bus.out_valid | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;

   // Address bits above the array are dropped, so addresses alias modulo the memory size.
   assign idx      = bus.aluResult[DEPTH_LOG2+1:2];
   assign lane     = bus.aluResult[1:0];
   assign is_store = bus.write;
   assign is_load  = bus.read & !bus.write;

   always_comb begin
      bad_align = 1'b1;
      case (bus.size)
         2'b00:   bad_align = 1'b0;
         2'b01:   bad_align = lane[0];
         2'b10:   bad_align = (lane != 2'b00);
         default: bad_align = 1'b1;
      endcase
   end

   assign op_err = (bus.read | bus.write) & bad_align;

   assign rd_word = mem[idx];
   assign ld_byte = rd_word[{lane, 3'b000} +: 8];
   assign ld_half = rd_word[{lane[1], 4'b0000} +: 16];

   always_comb begin
      ld_data = rd_word;
      case (bus.size)
         2'b00:   ld_data = {{(DATA_W-8){bus.sign_ext & ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = {{(DATA_W-16){bus.sign_ext & ld_half[15]}}, ld_half};
         default: ld_data = rd_word;
      endcase
   end

   // Replicating the store data across lanes lets the byte enables alone pick the target lanes.
   always_comb begin
      st_be   = '1;
      st_data = bus.writedata;
      case (bus.size)
         2'b00: begin
            st_be   = NB'(1) << lane;
            st_data = {NB{bus.writedata[7:0]}};
         end
         2'b01: begin
            st_be   = NB'(3) << lane;
            st_data = {(NB/2){bus.writedata[15:0]}};
         end
         default: begin
            st_be   = '1;
            st_data = bus.writedata;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept && is_store && !op_err) begin
         for (int b = 0; b < NB; b++) begin
            if (st_be[b]) begin
               mem[idx][b*8 +: 8] <= st_data[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.readdata  <= '0;
         bus.wbData    <= '0;
         bus.mem_err   <= 1'b0;
         bus.err_count <= '0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.mem_err   <= op_err;
         if (is_load && !op_err) begin
            bus.readdata <= ld_data;
            bus.wbData   <= ld_data;
         end else begin
            bus.readdata <= '0;
            bus.wbData   <= bus.aluResult;
         end
         if (op_err && (bus.err_count != '1)) begin
            bus.err_count <= bus.err_count + 1'b1;
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: hand-computed vectors checked with immediate assertions.
module tb_mem_stage_pipe;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   mem_stage_pipe_if #(.DATA_W(32), .ERRCNT_W(8)) bus ();

   mem_stage_pipe #(.DATA_W(32), .DEPTH_LOG2(8), .ERRCNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic setInputs(input logic vld, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic sx,
                            input logic [31:0] addr, input logic [31:0] wd);
      bus.in_valid  = vld;
      bus.read      = rd;
      bus.write     = wr;
      bus.size      = sz;
      bus.sign_ext  = sx;
      bus.aluResult = addr;
      bus.writedata = wd;
   endtask

   // One op presented for one edge; caller guarantees the stage is ready at that edge.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic sx, input logic [31:0] addr,
                                input logic [31:0] wd);
      setInputs(1'b1, rd, wr, sz, sx, addr, wd);
      @(posedge clk);
      #1;
      setInputs(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      bus.out_ready = 1'b1;
      setInputs(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
      checkOutput("reset_readdata", bus.readdata, 32'h0);
      checkOutput("reset_wbData", bus.wbData, 32'h0);
      checkOutput("reset_mem_err", {31'b0, bus.mem_err}, 32'h0);
      checkOutput("reset_err_count", {24'b0, bus.err_count}, 32'h0);
      checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'h1);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
      checkOutput("st10_out_valid", {31'b0, bus.out_valid}, 32'h1);
      checkOutput("st10_wbData", bus.wbData, 32'h10);
      checkOutput("st10_readdata", bus.readdata, 32'h0);

      applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
      checkOutput("ldb_sx_23", bus.readdata, 32'hFFFFFFDE);
      checkOutput("ldb_sx_23_wb", bus.wbData, 32'hFFFFFFDE);
      applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
      checkOutput("ldh_zx_20", bus.readdata, 32'h0000BEEF);
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h22, 32'h0);
      checkOutput("ldb_zx_22", bus.readdata, 32'h000000AD);
      applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
      checkOutput("ldh_sx_22", bus.readdata, 32'hFFFFDEAD);

      applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
      applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF5A);
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      checkOutput("ldw_after_stb", bus.readdata, 32'h11225A44);
      applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h9999CAFE);
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      checkOutput("ldw_after_sth", bus.readdata, 32'hCAFE5A44);

      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
      checkOutput("misalign_ld_err", {31'b0, bus.mem_err}, 32'h1);
      checkOutput("misalign_ld_rd", bus.readdata, 32'h0);
      checkOutput("misalign_ld_wb", bus.wbData, 32'h22);
      checkOutput("misalign_ld_cnt", {24'b0, bus.err_count}, 32'h1);
      applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF);
      checkOutput("misalign_st_cnt", {24'b0, bus.err_count}, 32'h2);
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      checkOutput("no_write_on_err", bus.readdata, 32'hCAFE5A44);
      checkOutput("clean_ld_err", {31'b0, bus.mem_err}, 32'h0);
      applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
      checkOutput("reserved_err", {31'b0, bus.mem_err}, 32'h1);
      applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
      checkOutput("half_odd_cnt", {24'b0, bus.err_count}, 32'h4);
      applyStimulus(1'b0, 1'b0, 2'b11, 1'b0, 32'h21, 32'h0);
      checkOutput("pass_no_err", {31'b0, bus.mem_err}, 32'h0);
      checkOutput("pass_no_cnt", {24'b0, bus.err_count}, 32'h4);

      applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h01020304);
      setInputs(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h55, 32'h0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      setInputs(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5A5A5);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
         checkOutput("stall_out_valid", {31'b0, bus.out_valid}, 32'h1);
         checkOutput("stall_wbData", bus.wbData, 32'h55);
      end
      setInputs(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
      bus.out_ready = 1'b1;
      #1;
      checkOutput("release_in_ready", {31'b0, bus.in_ready}, 32'h1);
      @(posedge clk);
      #1;
      checkOutput("stalled_store_dropped", bus.readdata, 32'h01020304);
      setInputs(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5A5A5);
      @(posedge clk);
      #1;
      checkOutput("b2b_store_wb", bus.wbData, 32'h30);
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
      checkOutput("b2b_load", bus.readdata, 32'hA5A5A5A5);
      @(posedge clk);
      #1;
      checkOutput("drain_out_valid", {31'b0, bus.out_valid}, 32'h0);
      checkOutput("drain_hold_wb", bus.wbData, 32'hA5A5A5A5);

      applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h420, 32'hABCD0123);
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h020, 32'h0);
      checkOutput("alias_420", bus.readdata, 32'hABCD0123);
      applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0);
      checkOutput("pass_wbData", bus.wbData, 32'h1234);
      checkOutput("pass_readdata", bus.readdata, 32'h0);
      applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h00000077);
      checkOutput("rw_as_store_rd", bus.readdata, 32'h0);
      checkOutput("rw_as_store_wb", bus.wbData, 32'h40);
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
      checkOutput("rw_store_landed", bus.readdata, 32'h00000077);

      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
      end
      checkOutput("err_count_sat", {24'b0, bus.err_count}, 32'hFF);

      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_out_valid", {31'b0, bus.out_valid}, 32'h0);
      checkOutput("midrst_readdata", bus.readdata, 32'h0);
      checkOutput("midrst_wbData", bus.wbData, 32'h0);
      checkOutput("midrst_err_count", {24'b0, bus.err_count}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      checkOutput("mem_survives_rst", bus.readdata, 32'h12345678);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
